fifo_wr_arbiter: RTL

Round-robin write arbiter sharing one `fifo` write port among `N_REQ` packet producers. It grants one requester at a time and holds the grant until that requester's `last` beat is accepted, so packets never interleave in the FIFO. It registers the FIFO write strobe and data, and throttles on the FIFO's `almost_full` and `full` flags. It sits directly in front of the `fifo` instance.

---
 rtl/fifo_wr_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter sharing one FIFO write port
// among N_REQ producers. A grant is held until the granted producer's last beat
// is accepted, so packets never interleave in the FIFO.
// Ports:
//   clk, arst (async, active-high), srst (sync, active-high)
//   req/last [N_REQ], data [N_REQ*DATA_WIDTH]  per-requester beat inputs
//   ack [N_REQ]        combinational beat accept
//   grant [N_REQ]      registered one-hot grant, zero when idle
//   fifo_almost_full, fifo_full  FIFO flags
//   fifo_wr, fifo_data registered FIFO write strobe and data
//   busy               high while a grant is held
//   timeout_err        one-cycle watchdog pulse
// Optional macro ARB_WATCHDOG_EN: releases a grant whose owner has left req low
// for TIMEOUT cycles; without it timeout_err is constant 0.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 128,
   parameter int N_REQ      = 4,
   parameter int TIMEOUT    = 256
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic                        srst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ-1:0]            last,
   input  logic [N_REQ*DATA_WIDTH-1:0] data,
   output logic [N_REQ-1:0]            ack,
   output logic [N_REQ-1:0]            grant,
   input  logic                        fifo_almost_full,
   input  logic                        fifo_full,
   output logic                        fifo_wr,
   output logic [DATA_WIDTH-1:0]       fifo_data,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef logic [PW-1:0] ptr_t;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   if (N_REQ < 2 || TIMEOUT < 1) begin : g_cfg_chk
      $error("fifo_wr_arbiter: need N_REQ >= 2 and TIMEOUT >= 1");
   end

   function automatic ptr_t ptr_inc(input ptr_t p);
      if (int'(p) == N_REQ - 1) return '0;
      return ptr_t'(int'(p) + 1);
   endfunction

   state_t                  state_q, state_d;
   logic [N_REQ-1:0]        grant_q, grant_d;
   ptr_t                    ptr_q, ptr_d;
   logic                    wr_q, wr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   logic                    found;
   ptr_t                    sel;
   ptr_t                    cand;
   ptr_t                    gidx;
   logic                    any_ack;
   logic                    glast;
   logic [DATA_WIDTH-1:0]   gdata;
   logic                    wd_fire;

   // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr_t'((int'(ptr_q) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) gidx = ptr_t'(i);
      end
   end

   // grant_q is only non-zero in LOCKED, so it qualifies ack by itself.
   // The flags gate at almost_full so the registered write always has a slot.
   assign ack     = grant_q & req &
                    {N_REQ{~fifo_almost_full & ~fifo_full}};
   assign any_ack = |ack;
   assign glast   = last[gidx];
   assign gdata   = data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      wr_d    = any_ack;
      data_d  = any_ack ? gdata : data_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               state_d      = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if ((any_ack && glast) || (!any_ack && wd_fire)) begin
               grant_d = '0;
               state_d = S_IDLE;
               ptr_d   = ptr_inc(gidx);
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else if (srst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
      end
   end

`ifdef ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          terr_q;
   logic          greq;

   assign greq    = req[gidx];
   assign wd_fire = (state_q == S_LOCKED) && (cnt_q == CW'(TIMEOUT));

   // Counts only cycles where the owner itself is silent; flag stalls
   // with req high are the FIFO's fault, not the producer's.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != S_LOCKED || any_ack || wd_fire) begin
         cnt_d = '0;
      end else if (!greq && cnt_q != CW'(TIMEOUT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else if (srst) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= wd_fire && !any_ack;
      end
   end

   assign timeout_err = terr_q;
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign grant     = grant_q;
   assign fifo_wr   = wr_q;
   assign fifo_data = data_q;
   assign busy      = (state_q == S_LOCKED);

endmodule
